// File: rtl/control_unit_pipe_if.sv
// ID/EX control bundle shared by the decode stage, the hazard unit and control_unit_pipe.
// The decode/hazard side uses the master modport; the control unit uses the slave modport.
interface control_unit_pipe_if;
    logic       valid_i;
    logic [6:0] op_i;
    logic [2:0] funct3_i;
    logic       funct7_5_i;
    logic       funct7_0_i;
    logic       stall_i;
    logic       flush_i;
    logic [2:0] ImmSelD_o;
    logic       busy_o;
    logic       validE_o;
    logic       RegWriteE_o;
    logic [1:0] ResultSrcE_o;
    logic       MemWriteE_o;
    logic       JumpE_o;
    logic       BranchE_o;
    logic       ALUSrcE_o;
    logic [2:0] ALUControlE_o;
    logic       ALUModifierE_o;
    logic       MulDivE_o;
    logic [2:0] MulDivOpE_o;
    logic       IllegalE_o;

    modport master (
        output valid_i, op_i, funct3_i, funct7_5_i, funct7_0_i, stall_i, flush_i,
        input  ImmSelD_o, busy_o, validE_o, RegWriteE_o, ResultSrcE_o, MemWriteE_o,
               JumpE_o, BranchE_o, ALUSrcE_o, ALUControlE_o, ALUModifierE_o,
               MulDivE_o, MulDivOpE_o, IllegalE_o
    );

    modport slave (
        input  valid_i, op_i, funct3_i, funct7_5_i, funct7_0_i, stall_i, flush_i,
        output ImmSelD_o, busy_o, validE_o, RegWriteE_o, ResultSrcE_o, MemWriteE_o,
               JumpE_o, BranchE_o, ALUSrcE_o, ALUControlE_o, ALUModifierE_o,
               MulDivE_o, MulDivOpE_o, IllegalE_o
    );
endinterface

// File: rtl/control_unit_pipe.sv
// RV32I/M control unit: decodes the ID instruction, registers the control word into ID/EX,
// and holds EX with busy_o for the duration of a multi-cycle MUL/DIV operation.
module control_unit_pipe #(
    parameter bit          ENABLE_M = 1'b1,
    parameter int unsigned MUL_LAT  = 3,
    parameter int unsigned DIV_LAT  = 8
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    control_unit_pipe_if.slave bus
);
    localparam int unsigned MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int unsigned CNT_W   = $clog2(MAX_LAT + 1);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef struct packed {
        logic       valid;
        logic       reg_write;
        logic [1:0] result_src;
        logic       mem_write;
        logic       jump;
        logic       branch;
        logic       alu_src;
        logic [2:0] alu_ctrl;
        logic       alu_mod;
        logic       mul_div;
        logic [2:0] mul_div_op;
        logic       illegal;
    } ctrl_t;

    typedef enum logic {IDLE, MD_BUSY} state_e;

    ctrl_t            dec;
    ctrl_t            ex_d;
    ctrl_t            ex_q;
    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] lat_d;
    logic             start_md;
    logic [2:0]       imm_sel;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        dec       = '0;
        dec.valid = 1'b1;
        imm_sel   = 3'b000;
        case (bus.op_i)
            OP_R: begin
                if (bus.funct7_0_i && !ENABLE_M) begin
                    dec.illegal = 1'b1;
                end else begin
                    dec.reg_write = 1'b1;
                    dec.alu_ctrl  = bus.funct3_i;
                    if (bus.funct7_0_i) begin
                        dec.mul_div    = 1'b1;
                        dec.mul_div_op = bus.funct3_i;
                    end else begin
                        dec.alu_mod = bus.funct7_5_i;
                    end
                end
            end
            OP_I: begin
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.alu_ctrl  = bus.funct3_i;
                // Only SRAI/SRLI use instr[30]; other immediates carry data there.
                dec.alu_mod   = (bus.funct3_i == 3'b101) && bus.funct7_5_i;
            end
            OP_LOAD: begin
                dec.reg_write  = 1'b1;
                dec.result_src = 2'b01;
                dec.alu_src    = 1'b1;
            end
            OP_STORE: begin
                dec.mem_write = 1'b1;
                dec.alu_src   = 1'b1;
                imm_sel       = 3'b001;
            end
            OP_BRANCH: begin
                dec.branch  = 1'b1;
                dec.alu_mod = 1'b1;
                imm_sel     = 3'b010;
            end
            OP_JAL: begin
                dec.reg_write  = 1'b1;
                dec.jump       = 1'b1;
                dec.result_src = 2'b10;
                imm_sel        = 3'b011;
            end
            OP_JALR: begin
                dec.reg_write  = 1'b1;
                dec.jump       = 1'b1;
                dec.result_src = 2'b10;
                dec.alu_src    = 1'b1;
            end
            OP_LUI: begin
                dec.reg_write  = 1'b1;
                dec.result_src = 2'b11;
                imm_sel        = 3'b100;
            end
            OP_AUIPC: begin
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                imm_sel       = 3'b100;
            end
            default: dec.illegal = 1'b1;
        endcase
        ex_d     = bus.valid_i ? dec : '0;
        lat_d    = bus.funct3_i[2] ? CNT_W'(DIV_LAT) : CNT_W'(MUL_LAT);
        start_md = ex_d.mul_div && (lat_d > CNT_W'(1));
    end

    // Flush wins over stall and busy; the M counter runs regardless of stall.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_ni || bus.flush_i) begin
            ex_q    <= '0;
            state_q <= IDLE;
            cnt_q   <= '0;
        end else if (state_q == MD_BUSY) begin
            cnt_q <= cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
                state_q <= IDLE;
            end
        end else if (!bus.stall_i) begin
            ex_q <= ex_d;
            if (start_md) begin
                state_q <= MD_BUSY;
                cnt_q   <= lat_d - CNT_W'(1);
            end
        end
    end

    assign bus.ImmSelD_o      = imm_sel;
    assign bus.busy_o         = (state_q == MD_BUSY);
    assign bus.validE_o       = ex_q.valid;
    assign bus.RegWriteE_o    = ex_q.reg_write;
    assign bus.ResultSrcE_o   = ex_q.result_src;
    assign bus.MemWriteE_o    = ex_q.mem_write;
    assign bus.JumpE_o        = ex_q.jump;
    assign bus.BranchE_o      = ex_q.branch;
    assign bus.ALUSrcE_o      = ex_q.alu_src;
    assign bus.ALUControlE_o  = ex_q.alu_ctrl;
    assign bus.ALUModifierE_o = ex_q.alu_mod;
    assign bus.MulDivE_o      = ex_q.mul_div;
    assign bus.MulDivOpE_o    = ex_q.mul_div_op;
    assign bus.IllegalE_o     = ex_q.illegal;
endmodule
